// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states, NOP word and FIFO entry layout.
package ifq_pkg;

  localparam logic [31:0] IFQ_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misaligned;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous circular FIFO of fetch entries with flush; flush wins over push and pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  ifq_entry_t    data_i,
  input  logic          pop_i,
  output ifq_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  ifq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding word read, registered FIFO toward decode, redirect flush.
// IFQ_MISALIGN_TRAP_EN: misaligned PCs push a NOP entry flagged on instr_misaligned instead of fetching.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = IFQ_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] pc_new,
  input  logic        redirect,
  output logic        pc_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4
`ifdef IFQ_MISALIGN_TRAP_EN
  ,
  output logic        instr_misaligned
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  ifq_state_e    state_q, state_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   pend_pc4_q, pend_pc4_d;
  logic          misalign;
  logic          trap_push;
  logic          fifo_push;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          room;
  ifq_entry_t    push_data;
  ifq_entry_t    head;

`ifdef IFQ_MISALIGN_TRAP_EN
  assign misalign = |address[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Room is judged against queued plus in-flight entries so a response never finds the FIFO full.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q != S_IDLE)};
  assign room      = occupancy < (CW + 1)'(DEPTH);
  assign mem_addr  = word_align(address);
  assign pc_stall  = ~((mem_req & mem_gnt) | trap_push);

  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    pend_pc4_d = pend_pc4_q;
    mem_req    = 1'b0;
    trap_push  = 1'b0;
    fifo_push  = 1'b0;
    push_data  = '{instr: mem_rdata, pc: pend_pc_q, pc4: pend_pc4_q, misaligned: 1'b0};
    case (state_q)
      S_IDLE: begin
        if (misalign) begin
          if (room && !redirect) begin
            trap_push = 1'b1;
            fifo_push = 1'b1;
            push_data = '{instr: NOP_INSTR, pc: address, pc4: pc_new, misaligned: 1'b1};
          end
        end else begin
          mem_req = room & ~redirect;
          if (mem_req && mem_gnt) begin
            pend_pc_d  = address;
            pend_pc4_d = pc_new;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          fifo_push = ~redirect;
          state_d   = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      trap_push = 1'b0;
      fifo_push = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_pc_q  <= '0;
      pend_pc4_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      pend_pc4_q <= pend_pc4_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .pop_i   (instr_ready),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = fifo_empty ? 32'h0 : head.pc;
  assign instr_pc4   = fifo_empty ? 32'h0 : head.pc4;

`ifdef IFQ_MISALIGN_TRAP_EN
  assign instr_misaligned = ~fifo_empty & head.misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = head.misaligned;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed plus random bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, redirect, mem_gnt, mem_rvalid, instr_ready;
  logic [31:0] address, pc_new, mem_rdata;
  logic        pc_stall, mem_req, instr_valid;
  logic [31:0] mem_addr, instr, instr_pc, instr_pc4;
`ifdef IFQ_MISALIGN_TRAP_EN
  logic        instr_misaligned;
`endif

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .pc_new      (pc_new),
    .redirect    (redirect),
    .pc_stall    (pc_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_pc4   (instr_pc4)
`ifdef IFQ_MISALIGN_TRAP_EN
    ,
    .instr_misaligned (instr_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
  } ent_t;

  // Reference model: queued entries, one in-flight read (possibly doomed), upstream PC.
  ent_t        q[$];
  bit          outst, dropping;
  logic [31:0] ppc, ppc4;
  logic [31:0] pc;
  int          ncmp = 0;
  int          nfail = 0;

  logic        s_reset, s_redirect, s_gnt, s_rvalid, s_ready;
  logic [31:0] s_rdata, s_target;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic exp_req, exp_stall, mis, tpush, pop;
    @(negedge clk);
    reset       = s_reset;
    redirect    = s_redirect;
    mem_gnt     = s_gnt;
    mem_rvalid  = s_rvalid;
    mem_rdata   = s_rdata;
    instr_ready = s_ready;
    address     = pc;
    pc_new      = pc + 32'd4;
    #1;
`ifdef IFQ_MISALIGN_TRAP_EN
    mis = (pc[1:0] != 2'b00) && !outst;
`else
    mis = 1'b0;
`endif
    exp_req   = !s_reset && !outst && !mis && !s_redirect && (q.size() < DEPTH);
    tpush     = mis && !s_reset && !s_redirect && (q.size() < DEPTH);
    exp_stall = !(exp_req && s_gnt) && !tpush;

    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("mem_addr", mem_addr, pc & 32'hFFFF_FFFC);
    chk("pc_stall", 32'(pc_stall), 32'(exp_stall));
    chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("instr", instr, q[0].instr);
      chk("instr_pc", instr_pc, q[0].pc);
      chk("instr_pc4", instr_pc4, q[0].pc4);
`ifdef IFQ_MISALIGN_TRAP_EN
      chk("instr_mis", 32'(instr_misaligned), 32'(q[0].mis));
`endif
    end else if (s_reset) begin
      chk("rst_instr", instr, NOP);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pc4", instr_pc4, 32'h0);
    end

    pop = (q.size() > 0) && s_ready;
    if (s_reset) begin
      q.delete();
      outst    = 1'b0;
      dropping = 1'b0;
    end else if (s_redirect) begin
      q.delete();
      if (outst && s_rvalid) begin
        outst    = 1'b0;
        dropping = 1'b0;
      end else if (outst) begin
        dropping = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (outst && s_rvalid) begin
        if (!dropping) q.push_back('{instr: s_rdata, pc: ppc, pc4: ppc4, mis: 1'b0});
        outst    = 1'b0;
        dropping = 1'b0;
      end
      if (tpush) q.push_back('{instr: NOP, pc: pc, pc4: pc + 32'd4, mis: 1'b1});
      if (exp_req && s_gnt) begin
        outst = 1'b1;
        ppc   = pc;
        ppc4  = pc + 32'd4;
      end
    end
    if (!s_reset) begin
      if (s_redirect) pc = s_target;
      else if (!exp_stall) pc = pc + 32'd4;
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; instr_ready = 1'b0; address = '0; pc_new = 32'd4;
    pc = '0; outst = 1'b0; dropping = 1'b0; ppc = '0; ppc4 = '0;
    s_reset = 1'b1; s_redirect = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
    s_rdata = '0; s_ready = 1'b0; s_target = '0;
    repeat (2) @(posedge clk);

    // reset state
    step();
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(pc_stall), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // basic fetch: grant N, rvalid N+1, visible N+2
    s_reset = 1'b0; s_gnt = 1'b1;
    step();
    chk("bf_req", 32'(mem_req), 32'd1);
    chk("bf_stall", 32'(pc_stall), 32'd0);
    s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h00500093;
    step();
    chk("bf_valid_n1", 32'(instr_valid), 32'd0);
    s_rvalid = 1'b0;
    step();
    chk("bf_valid", 32'(instr_valid), 32'd1);
    chk("bf_instr", instr, 32'h00500093);
    chk("bf_pc", instr_pc, 32'h0);
    chk("bf_pc4", instr_pc4, 32'h4);

    // backpressure: fill to DEPTH, then drain in order
    s_ready = 1'b0; s_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = outst;
      s_rdata  = $urandom;
      step();
    end
    chk("bp_req", 32'(mem_req), 32'd0);
    chk("bp_stall", 32'(pc_stall), 32'd1);
    s_ready = 1'b1; s_gnt = 1'b0; s_rvalid = 1'b0;
    step();
    chk("bp_pop0", instr_pc, 32'h0);
    step();
    chk("bp_pop1", instr_pc, 32'h4);
    step();
    chk("bp_empty", 32'(instr_valid), 32'd0);

    // redirect while a read to 0x8 is in flight
    s_ready = 1'b0; s_gnt = 1'b1;
    step();
    chk("rd_grant_addr", mem_addr, 32'h8);
    s_gnt = 1'b0; s_redirect = 1'b1; s_target = 32'h100;
    step();
    s_redirect = 1'b0;
    step();
    chk("rd_drop_req", 32'(mem_req), 32'd0);
    step();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    step();
    s_rvalid = 1'b0;
    step();
    chk("rd_valid", 32'(instr_valid), 32'd0);
    chk("rd_req", 32'(mem_req), 32'd1);
    chk("rd_addr", mem_addr, 32'h100);

    // grant wait states
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_req", 32'(mem_req), 32'd1);
      chk("ws_addr", mem_addr, 32'h100);
      chk("ws_stall", 32'(pc_stall), 32'd1);
    end
    s_gnt = 1'b1;
    step();
    chk("ws_stall_gnt", 32'(pc_stall), 32'd0);
    s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h12345678;
    step();
    s_rvalid = 1'b0;
    step();
    chk("ws_instr", instr, 32'h12345678);
    chk("ws_pc", instr_pc, 32'h100);

    // reset while waiting, then a stale response
    s_ready = 1'b1; s_gnt = 1'b1;
    step();
    s_gnt = 1'b0; s_reset = 1'b1;
    step();
    s_reset = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hBADBAD00;
    step();
    s_rvalid = 1'b0;
    step();
    chk("rw_valid", 32'(instr_valid), 32'd0);

    // misaligned PC
    s_ready = 1'b0; s_redirect = 1'b1; s_target = 32'h6;
    step();
    s_redirect = 1'b0;
    step();
`ifdef IFQ_MISALIGN_TRAP_EN
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_stall", 32'(pc_stall), 32'd0);
    step();
    chk("mis_instr", instr, 32'h00000013);
    chk("mis_flag", 32'(instr_misaligned), 32'd1);
    chk("mis_pc", instr_pc, 32'h6);
`else
    chk("mis_req", 32'(mem_req), 32'd1);
    chk("mis_addr", mem_addr, 32'h4);
`endif
    s_redirect = 1'b1; s_target = 32'h200;
    step();
    s_redirect = 1'b0;

    // streaming with simultaneous push and pop
    s_ready = 1'b1; s_gnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_rvalid = outst;
      s_rdata  = $urandom;
      step();
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      s_reset    = ($urandom_range(0, 99) == 0);
      s_redirect = ($urandom_range(0, 19) == 0);
      s_target   = $urandom;
      if ($urandom_range(0, 3) != 0) s_target[1:0] = 2'b00;
      s_gnt      = ($urandom_range(0, 1) == 1);
      s_ready    = ($urandom_range(0, 2) != 0);
      s_rvalid   = outst && ($urandom_range(0, 2) == 0);
      s_rdata    = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
